// File: rtl/encoder_pkg.sv
// Shared constants, FSM state type and popcount helper for the 16-to-4 stream encoder.
package encoder_pkg;

  localparam int REQ_N = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] popcount16(input logic [REQ_N-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < REQ_N; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/encoder164_stream_prio_sel16.sv
// Combinational 16-way selector: first set bit of mask at index >= start_i, wrapping 15 -> 0.
module prio_sel16
  import encoder_pkg::*;
(
  input  logic [REQ_N-1:0] mask_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [IDX_W-1:0] j;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    j       = '0;
    for (int i = 0; i < REQ_N; i++) begin
      // 4-bit add wraps the search window around index 15.
      j = start_i + IDX_W'(i);
      if (!found_o && mask_i[j]) begin
        found_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/encoder164_stream.sv
// Sticky 16-bit request register drained one index per valid/ready handshake.
// Define ENCODER164_RR_EN for round-robin selection; default is lowest-index priority.
module encoder164_stream
  import encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_N-1:0] dataIn,
  input  logic             dataInValid,
  output logic [IDX_W-1:0] dataOut,
  output logic             dataOutValid,
  input  logic             dataOutReady,
  output logic [REQ_N-1:0] pending,
  output logic [CNT_W-1:0] pendCount,
  output state_t           dbg_state_o
);

  // Handshake: dataOutValid && dataOutReady at the rising edge. dataOut and
  // dataOutValid are registered and never change while waiting for ready.
  state_t           state_q;
  logic [REQ_N-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] data_out_q;
  logic             data_out_valid_q;

  logic             hs;
  logic [REQ_N-1:0] clr_mask;
  logic [REQ_N-1:0] pend_cleared;
  logic [IDX_W-1:0] sel_start;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;

  assign hs           = data_out_valid_q && dataOutReady;
  assign clr_mask     = hs ? ({{(REQ_N-1){1'b0}}, 1'b1} << data_out_q) : '0;
  assign pend_cleared = pending_q & ~clr_mask;
  // New requests are OR-ed after the clear, so a re-request survives its own handshake.
  assign pending_d    = pend_cleared | (dataInValid ? dataIn : '0);

`ifdef ENCODER164_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign ptr_d     = hs ? (data_out_q + IDX_W'(1)) : ptr_q;
  assign sel_start = ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign sel_start = '0;
`endif

  // Selection sees only registered pending minus the bit being retired.
  prio_sel16 u_sel (
    .mask_i  (pend_cleared),
    .start_i (sel_start),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      pending_q        <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            data_out_q       <= sel_idx;
            data_out_valid_q <= 1'b1;
            state_q          <= OFFER;
          end
        end
        OFFER: begin
          if (hs) begin
            if (sel_found) begin
              data_out_q <= sel_idx;
            end else begin
              data_out_valid_q <= 1'b0;
              state_q          <= IDLE;
            end
          end
        end
        default: begin
          data_out_valid_q <= 1'b0;
          state_q          <= IDLE;
        end
      endcase
    end
  end

  assign dataOut      = data_out_q;
  assign dataOutValid = data_out_valid_q;
  assign pending      = pending_q;
  assign pendCount    = popcount16(pending_q);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_encoder164_stream.sv
// Directed bench for encoder164_stream: vector table plus drain, reset and round-robin sequences.
module tb_encoder164_stream;
  import encoder_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [REQ_N-1:0] dataIn;
  logic             dataInValid;
  logic [IDX_W-1:0] dataOut;
  logic             dataOutValid;
  logic             dataOutReady;
  logic [REQ_N-1:0] pending;
  logic [CNT_W-1:0] pendCount;
  state_t           dbg_state;

  int tests = 0;
  int fails = 0;

  logic [IDX_W-1:0] exp_q[$];

  typedef struct {
    logic [15:0] din;
    logic        dv;
    logic        rdy;
    logic [3:0]  e_out;
    logic        e_val;
    logic [15:0] e_pend;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t vecs[23];

  encoder164_stream dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dataIn       (dataIn),
    .dataInValid  (dataInValid),
    .dataOut      (dataOut),
    .dataOutValid (dataOutValid),
    .dataOutReady (dataOutReady),
    .pending      (pending),
    .pendCount    (pendCount),
    .dbg_state_o  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [15:0] din, input logic dv, input logic rdy);
    dataIn       = din;
    dataInValid  = dv;
    dataOutReady = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 16'(dataOut), 16'h0);
    check("rst_val", 16'(dataOutValid), 16'h0);
    check("rst_pend", pending, 16'h0000);
    check("rst_cnt", 16'(pendCount), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    drive(vecs[i].din, vecs[i].dv, vecs[i].rdy);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_out", i), 16'(dataOut), 16'(vecs[i].e_out));
    check($sformatf("v%0d_val", i), 16'(dataOutValid), 16'(vecs[i].e_val));
    check($sformatf("v%0d_pend", i), pending, vecs[i].e_pend);
    check($sformatf("v%0d_cnt", i), 16'(pendCount), 16'(vecs[i].e_cnt));
  endtask

  initial begin
    int cycles;

    // Columns: din, dv, rdy | out, valid, pending, count  (observed just after the edge)
    vecs[0]  = '{16'h0000, 1'b1, 1'b1, 4'h0, 1'b0, 16'h0000, 5'd0};  // zero request is a no-op
    vecs[1]  = '{16'h0000, 1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 5'd0};  // ready ignored in IDLE
    vecs[2]  = '{16'h0100, 1'b1, 1'b1, 4'h0, 1'b0, 16'h0100, 5'd1};  // single request, edge N
    vecs[3]  = '{16'h0000, 1'b0, 1'b1, 4'h8, 1'b1, 16'h0100, 5'd1};  // offer after N+1
    vecs[4]  = '{16'h0000, 1'b0, 1'b1, 4'h8, 1'b0, 16'h0000, 5'd0};  // handshake, back to IDLE
    vecs[5]  = '{16'h8421, 1'b1, 1'b1, 4'h8, 1'b0, 16'h8421, 5'd4};  // multi-hot
    vecs[6]  = '{16'h0000, 1'b0, 1'b1, 4'h0, 1'b1, 16'h8421, 5'd4};
    vecs[7]  = '{16'h0000, 1'b0, 1'b1, 4'h5, 1'b1, 16'h8420, 5'd3};
    vecs[8]  = '{16'h0000, 1'b0, 1'b1, 4'hA, 1'b1, 16'h8400, 5'd2};
    vecs[9]  = '{16'h0000, 1'b0, 1'b1, 4'hF, 1'b1, 16'h8000, 5'd1};
    vecs[10] = '{16'h0000, 1'b0, 1'b1, 4'hF, 1'b0, 16'h0000, 5'd0};
    vecs[11] = '{16'h0010, 1'b1, 1'b0, 4'hF, 1'b0, 16'h0010, 5'd1};  // hold stability
    vecs[12] = '{16'h0000, 1'b0, 1'b0, 4'h4, 1'b1, 16'h0010, 5'd1};
    vecs[13] = '{16'h0001, 1'b1, 1'b0, 4'h4, 1'b1, 16'h0011, 5'd2};  // higher priority arrives
    vecs[14] = '{16'h0000, 1'b0, 1'b0, 4'h4, 1'b1, 16'h0011, 5'd2};
    vecs[15] = '{16'h0000, 1'b0, 1'b1, 4'h0, 1'b1, 16'h0001, 5'd1};
    vecs[16] = '{16'h0000, 1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 5'd0};
    vecs[17] = '{16'h0008, 1'b1, 1'b0, 4'h0, 1'b0, 16'h0008, 5'd1};  // set-wins
    vecs[18] = '{16'h0000, 1'b0, 1'b0, 4'h3, 1'b1, 16'h0008, 5'd1};
    vecs[19] = '{16'h0008, 1'b1, 1'b1, 4'h3, 1'b0, 16'h0008, 5'd1};
    vecs[20] = '{16'h0000, 1'b0, 1'b1, 4'h3, 1'b1, 16'h0008, 5'd1};
    vecs[21] = '{16'h0000, 1'b0, 1'b1, 4'h3, 1'b0, 16'h0000, 5'd0};
    vecs[22] = '{16'hFFFF, 1'b0, 1'b1, 4'h3, 1'b0, 16'h0000, 5'd0};  // invalid data ignored

    do_reset();

`ifndef ENCODER164_RR_EN
    for (int i = 0; i < 23; i++) run_vec(i);

    // Full drain: 16 handshakes on consecutive cycles, indices 0..15.
    for (int i = 0; i < 16; i++) exp_q.push_back(IDX_W'(i));
    @(negedge clk);
    drive(16'hFFFF, 1'b1, 1'b1);
    @(negedge clk);
    drive(16'h0000, 1'b0, 1'b1);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 40) begin
      if (dataOutValid) begin
        check("drain_cnt", 16'(pendCount), 16'(exp_q.size()));
        check("drain_idx", 16'(dataOut), 16'(exp_q.pop_front()));
      end
      cycles++;
      @(negedge clk);
    end
    check("drain_left", 16'(exp_q.size()), 16'd0);
    check("drain_cycles", 16'(cycles), 16'd17);
    check("drain_final_cnt", 16'(pendCount), 16'd0);
    check("drain_final_val", 16'(dataOutValid), 16'd0);
`else
    // Round-robin: 0003 then re-request of 0 during the offer of 1 gives 0, 1, 0.
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h0);
    @(negedge clk);
    drive(16'h0003, 1'b1, 1'b1);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 20) begin
      @(negedge clk);
      if (dataOutValid && dataOut == 4'h1) drive(16'h0001, 1'b1, 1'b1);
      else drive(16'h0000, 1'b0, 1'b1);
      if (dataOutValid) check("rr_order", 16'(dataOut), 16'(exp_q.pop_front()));
      cycles++;
    end
    check("rr_left", 16'(exp_q.size()), 16'd0);
    // Pointer now 1: 0005 must pick 2 first.
    @(negedge clk);
    drive(16'h0005, 1'b1, 1'b0);
    @(negedge clk);
    drive(16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("rr_ptr_pick", 16'(dataOut), 16'h2);
    check("rr_ptr_val", 16'(dataOutValid), 16'h1);
    // Mid-offer reset also clears the pointer: 0005 then picks 0.
    #2 rst_n = 1'b0;
    #1;
    check("rr_rst_val", 16'(dataOutValid), 16'h0);
    check("rr_rst_pend", pending, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'h0005, 1'b1, 1'b0);
    @(negedge clk);
    drive(16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("rr_after_rst_pick", 16'(dataOut), 16'h0);
    check("rr_after_rst_val", 16'(dataOutValid), 16'h1);
    @(negedge clk);
    drive(16'h0000, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
`endif

    // Mid-offer asynchronous reset drops valid and pending immediately.
    @(negedge clk);
    drive(16'h00F0, 1'b1, 1'b0);
    @(negedge clk);
    drive(16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_val_before", 16'(dataOutValid), 16'h1);
    check("mid_out_before", 16'(dataOut), 16'h4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_val", 16'(dataOutValid), 16'h0);
    check("mid_rst_out", 16'(dataOut), 16'h0);
    check("mid_rst_pend", pending, 16'h0000);
    check("mid_rst_cnt", 16'(pendCount), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    check("post_rst_val", 16'(dataOutValid), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/encoder164_stream.md
# encoder164_stream

Sequential 16-to-4 request encoder, the inverse of the team's 4-to-16 one-hot decoder. It accumulates multi-hot request bits into a sticky pending vector and emits one 4-bit index per valid/ready handshake. Each emitted index clears its pending bit. It sits between event/interrupt sources and any consumer that drives a 4-to-16 decoder or indexes a 16-entry resource.

## Interface
- Parameters: none. Width is fixed at 16 requests / 4-bit index, with constants in the package.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dataIn  in  16  request bits; bit i requests index i.
- dataInValid  in  1  when high, dataIn is OR-merged into pending at this edge.
- dataOut  out  4  index of the offered request.
- dataOutValid  out  1  dataOut holds a valid index.
- dataOutReady  in  1  consumer accepts dataOut.
- pending  out  16  current sticky request register.
- pendCount  out  5  popcount of pending, range 0..16.

## Operation
- The pending register updates each edge as follows: pending <= (pending & ~clrMask) | (dataInValid ? dataIn : 0).
  - clrMask is the one-hot of dataOut on a handshake, otherwise 0.
- Set wins over clear: a bit re-requested in its own handshake cycle stays pending.
- FSM states (encoder_pkg::state_t):
  - IDLE: dataOutValid=0. If pending != 0, latch the selected index into dataOut and go to OFFER.
  - OFFER: dataOutValid=1. dataOut and dataOutValid are held stable until dataOutReady.
    - On handshake, selection runs on (pending & ~clrMask), using the registered value only, not the same-cycle dataIn.
    - If that value is nonzero: latch the new index and stay in OFFER (back-to-back).
    - Otherwise: go to IDLE.
- Selection is fixed priority: the lowest set index wins. A round-robin alternative is described under Configuration.
- Requests arriving during OFFER never disturb the held dataOut, even if they have higher priority.
- dataIn with dataInValid=0 is ignored. dataInValid with dataIn=0 is a no-op.
- pendCount is derived combinationally from the pending register.

## Timing
- Reset values, applied asynchronously and immediately:
  - pending=0, pendCount=0, dataOut=0, dataOutValid=0.
  - state=IDLE.
  - Round-robin pointer=0.
- Reset asserted mid-OFFER drops dataOutValid at once. No handshake is reported for that cycle.
- Latency from an empty block: dataInValid at edge N, then pending is visible after N, then dataOutValid=1 after edge N+1, i.e. 2 cycles.
- Throughput: one index per cycle while pending holds other bits and dataOutReady is held high.
- Handshake occurs in a cycle where dataOutValid && dataOutReady at the rising edge.
- dataOutReady is ignored in IDLE.
- If all 16 bits are pending, exactly 16 handshakes drain the block and pendCount reaches 0. Duplicate requests to an already-pending bit are absorbed; there is no overflow.

## Configuration
- ENCODER164_RR_EN defined: round-robin selection.
  - A 4-bit pointer (reset 0) is used; the first set bit at index >= pointer wins, wrapping from 15 to 0.
  - On each handshake, pointer <= dataOut + 1 (mod 16).
  - Selection for the back-to-back case uses the updated pointer.
- ENCODER164_RR_EN undefined: fixed lowest-index priority. No pointer register exists.

## Structure
- encoder_pkg:
  - REQ_N=16, IDX_W=4, CNT_W=5.
  - typedef enum logic {IDLE, OFFER} state_t.
- Sub-module prio_sel16: purely combinational.
  - Inputs: 16-bit mask and a 4-bit start index. Outputs: 4-bit index and a found flag.
  - Without RR, start is tied to 0.
  - Instantiated once in encoder164_stream.

## Test plan
- Reset, then dataIn=16'h0000 with valid: outputs stay at their reset values, pendCount=0, and dataOutValid never rises.
- Single request 16'h0100 at edge N with dataOutReady=1: dataOut=4'h8 and dataOutValid=1 after N+1. After the handshake, pending=0 and the FSM returns to IDLE.
- Multi-hot 16'h8421 with ready held high: fixed mode emits 0, 5, 10, 15 on consecutive cycles. pendCount goes 4, 3, 2, 1, 0.
- Hold stability: offer index 4 with ready=0, then inject 16'h0001. dataOut stays 4 until ready. Index 0 follows next, and pendCount shows 2 while the offer is held.
- Set-wins: handshake on index 3 in the same cycle as dataIn=16'h0008 valid. pending bit 3 remains set and index 3 is re-emitted later.
- With ENCODER164_RR_EN: pending 16'h0003 plus a later 16'h0001 re-request gives the order 0, 1, then 0. A mid-OFFER rst_n pulse clears pending and the pointer immediately.
